// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] FETCH_BYTES = 32'd8;
  localparam int          SLOTS       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]      pc;
    logic [63:0]      instr;
    logic [SLOTS-1:0] slot_mask;
  } bundle_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] fetch_align(input logic [31:0] a);
    return a & 32'hFFFF_FFF8;
  endfunction

endpackage

// File: rtl/adder_32.sv
// Shared 32-bit adder with carry-out.
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC register, one outstanding 8-byte fetch, output register
// plus one-entry skid toward decode, redirect squashing and halt.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [63:0] imem_rsp_data_i,
  output logic        fd_valid_o,
  output logic [31:0] fd_pc_o,
  output logic [63:0] fd_instr_o,
  output logic [1:0]  fd_slot_mask_o,
  input  logic        fd_ready_i
);

  localparam logic [31:0] RESET_PC_W = word_align(RESET_PC);

  fetch_state_e state_r, state_n;
  logic [31:0]  pc_r, pc_n;
  logic [31:0]  req_pc_r, req_pc_n;
  logic [31:0]  next_pc_s;
  logic         squash_r, squash_n;
  logic         out_valid_r, out_valid_n;
  logic         skid_valid_r, skid_valid_n;
  bundle_t      out_r, out_n, skid_r, skid_n, rsp_bundle_s;
  logic         req_fire_s, drain_s, out_free_s, carry_unused_s;

  assign imem_req_valid_o = (state_r == REQ) && !halt_i;
  assign imem_req_addr_o  = fetch_align(pc_r);
  assign req_fire_s       = imem_req_valid_o && imem_req_ready_i;
  assign drain_s          = out_valid_r && fd_ready_i;
  assign out_free_s       = !out_valid_r || drain_s;

  assign fd_valid_o     = out_valid_r;
  assign fd_pc_o        = out_r.pc;
  assign fd_instr_o     = out_r.instr;
  assign fd_slot_mask_o = out_r.slot_mask;

  // Carry out of the top bit is dropped so the PC wraps to zero.
  adder_32 u_next_pc (
    .a     (fetch_align(req_pc_r)),
    .b     (FETCH_BYTES),
    .sum   (next_pc_s),
    .carry (carry_unused_s)
  );

  // Build the decode bundle from the memory response; slot 0 is empty for odd-word targets.
  always_comb begin
    rsp_bundle_s.pc        = req_pc_r;
    rsp_bundle_s.slot_mask = {1'b1, ~req_pc_r[2]};
    if (req_pc_r[2]) begin
      rsp_bundle_s.instr = {imem_rsp_data_i[63:32], NOP_INSTR};
    end else begin
      rsp_bundle_s.instr = imem_rsp_data_i;
    end
  end

  // Next-state logic: redirect overrides everything except reset.
  always_comb begin
    state_n      = state_r;
    pc_n         = pc_r;
    req_pc_n     = req_pc_r;
    squash_n     = squash_r;
    skid_valid_n = skid_valid_r;
    skid_n       = skid_r;
    if (drain_s) begin
      out_valid_n = 1'b0;
      out_n       = '0;
    end else begin
      out_valid_n = out_valid_r;
      out_n       = out_r;
    end

    if (redirect_valid_i) begin
      pc_n         = word_align(redirect_pc_i);
      out_valid_n  = 1'b0;
      out_n        = '0;
      skid_valid_n = 1'b0;
      skid_n       = '0;
      case (state_r)
        WAIT: begin
          if (imem_rsp_valid_i) begin
            squash_n = 1'b0;
            state_n  = REQ;
          end else begin
            squash_n = 1'b1;
            state_n  = WAIT;
          end
        end
        REQ: begin
          // The request already on the bus still goes out; its response is dropped.
          if (req_fire_s) begin
            req_pc_n = pc_r;
            squash_n = 1'b1;
            state_n  = WAIT;
          end else begin
            squash_n = 1'b0;
            state_n  = REQ;
          end
        end
        default: begin
          squash_n = 1'b0;
          state_n  = REQ;
        end
      endcase
    end else begin
      case (state_r)
        IDLE: begin
          if (halt_i) begin
            state_n = IDLE;
          end else begin
            state_n = REQ;
          end
        end
        REQ: begin
          if (req_fire_s) begin
            req_pc_n = pc_r;
            state_n  = WAIT;
          end else begin
            state_n = REQ;
          end
        end
        WAIT: begin
          if (!imem_rsp_valid_i) begin
            state_n = WAIT;
          end else if (squash_r) begin
            squash_n = 1'b0;
            state_n  = REQ;
          end else if (out_free_s) begin
            out_valid_n = 1'b1;
            out_n       = rsp_bundle_s;
            pc_n        = next_pc_s;
            state_n     = REQ;
          end else begin
            skid_valid_n = 1'b1;
            skid_n       = rsp_bundle_s;
            pc_n         = next_pc_s;
            state_n      = HOLD;
          end
        end
        HOLD: begin
          if (out_free_s) begin
            out_valid_n  = 1'b1;
            out_n        = skid_r;
            skid_valid_n = 1'b0;
            skid_n       = '0;
            state_n      = REQ;
          end else begin
            state_n = HOLD;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, PC and bundle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC_W;
      req_pc_r     <= 32'h0000_0000;
      squash_r     <= 1'b0;
      out_valid_r  <= 1'b0;
      out_r        <= '0;
      skid_valid_r <= 1'b0;
      skid_r       <= '0;
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      req_pc_r     <= req_pc_n;
      squash_r     <= squash_n;
      out_valid_r  <= out_valid_n;
      out_r        <= out_n;
      skid_valid_r <= skid_valid_n;
      skid_r       <= skid_n;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a small latency-programmable memory model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i = 1'b1;
  logic        imem_rsp_valid_i = 1'b0;
  logic [63:0] imem_rsp_data_i = 64'h0;
  logic        fd_valid_o;
  logic [31:0] fd_pc_o;
  logic [63:0] fd_instr_o;
  logic [1:0]  fd_slot_mask_o;
  logic        fd_ready_i = 1'b1;

  int checks = 0;
  int errors = 0;
  int lat = 1;

  logic [31:0] req_q[$];
  logic [31:0] bpc_q[$];
  logic [63:0] binstr_q[$];
  logic [1:0]  bmask_q[$];

  fetch_pc_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .halt_i           (halt_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .fd_valid_o       (fd_valid_o),
    .fd_pc_o          (fd_pc_o),
    .fd_instr_o       (fd_instr_o),
    .fd_slot_mask_o   (fd_slot_mask_o),
    .fd_ready_i       (fd_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    req_q.delete();
    bpc_q.delete();
    binstr_q.delete();
    bmask_q.delete();
  endtask

  task automatic wait_reqs(input int n);
    for (int i = 0; i < 60 && req_q.size() < n; i++) cyc();
    check_val("req_count", 64'(req_q.size()), 64'(n));
  endtask

  task automatic wait_bundles(input int n);
    for (int i = 0; i < 60 && bpc_q.size() < n; i++) cyc();
    check_val("bundle_count", 64'(bpc_q.size()), 64'(n));
  endtask

  task automatic wait_req_valid();
    for (int i = 0; i < 40 && !imem_req_valid_o; i++) cyc();
    check_val("req_valid_seen", 64'(imem_req_valid_o), 64'h1);
  endtask

  task automatic redirect_to(input logic [31:0] addr);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = addr;
    cyc();
    redirect_valid_i = 1'b0;
    clear_q();
  endtask

  // Memory: respond 'lat' cycles after each accepted request.
  initial begin : mem_model
    int cnt;
    logic [31:0] a;
    cnt = 0;
    a = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_req_valid_o && imem_req_ready_i) begin
        cnt = lat;
        a = imem_req_addr_o;
      end
      @(posedge clk);
      #1;
      if (cnt == 1) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = {word_at(a + 32'd4), word_at(a)};
        cnt = 0;
      end else begin
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 64'h0;
        if (cnt > 0) cnt--;
      end
    end
  end

  // Record accepted requests and delivered bundles.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (fd_valid_o && fd_ready_i) begin
        bpc_q.push_back(fd_pc_o);
        binstr_q.push_back(fd_instr_o);
        bmask_q.push_back(fd_slot_mask_o);
      end
      if (imem_req_valid_o && imem_req_ready_i) req_q.push_back(imem_req_addr_o);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    // Reset state
    repeat (3) cyc();
    check_val("rst_req_valid", 64'(imem_req_valid_o), 64'h0);
    check_val("rst_req_addr", 64'(imem_req_addr_o), 64'h0);
    check_val("rst_fd_valid", 64'(fd_valid_o), 64'h0);
    check_val("rst_fd_pc", 64'(fd_pc_o), 64'h0);
    check_val("rst_fd_instr", fd_instr_o, 64'h0);
    check_val("rst_fd_mask", 64'(fd_slot_mask_o), 64'h0);

    // Sequential fetch from reset
    lat = 1;
    clear_q();
    rst_n = 1'b1;
    wait_reqs(3);
    check_val("seq_req0", 64'(req_q[0]), 64'h0);
    check_val("seq_req1", 64'(req_q[1]), 64'h8);
    check_val("seq_req2", 64'(req_q[2]), 64'h10);
    wait_bundles(2);
    check_val("seq_b0_pc", 64'(bpc_q[0]), 64'h0);
    check_val("seq_b0_instr", binstr_q[0], 64'h1000_0004_1000_0000);
    check_val("seq_b0_mask", 64'(bmask_q[0]), 64'h3);
    check_val("seq_b1_pc", 64'(bpc_q[1]), 64'h8);
    check_val("seq_b1_instr", binstr_q[1], 64'h1000_000C_1000_0008);

    // Redirect in WAIT with the stale response one cycle later
    lat = 2;
    wait_req_valid();
    cyc();
    check_val("rd_in_wait", 64'(imem_req_valid_o), 64'h0);
    redirect_to(32'h0000_0104);
    check_val("rd_fd_flushed", 64'(fd_valid_o), 64'h0);
    check_val("rd_addr", 64'(imem_req_addr_o), 64'h100);
    check_val("rd_still_wait", 64'(imem_req_valid_o), 64'h0);
    cyc();
    check_val("rd_stale_dropped", 64'(fd_valid_o), 64'h0);
    check_val("rd_req_again", 64'(imem_req_valid_o), 64'h1);
    wait_bundles(1);
    check_val("rd_b0_pc", 64'(bpc_q[0]), 64'h104);
    check_val("rd_b0_mask", 64'(bmask_q[0]), 64'h2);
    check_val("rd_b0_instr", binstr_q[0], 64'h1000_0104_0000_0000);
    wait_reqs(2);
    check_val("rd_req0", 64'(req_q[0]), 64'h100);
    check_val("rd_req1", 64'(req_q[1]), 64'h108);

    // Backpressure: output holds, second bundle goes to skid, no third request
    lat = 1;
    fd_ready_i = 1'b0;
    redirect_to(32'h0000_0200);
    for (int i = 0; i < 40 && !fd_valid_o; i++) cyc();
    check_val("bp_fd_valid", 64'(fd_valid_o), 64'h1);
    check_val("bp_fd_pc", 64'(fd_pc_o), 64'h200);
    check_val("bp_fd_instr", fd_instr_o, 64'h1000_0204_1000_0200);
    check_val("bp_fd_mask", 64'(fd_slot_mask_o), 64'h3);
    for (int i = 0; i < 7; i++) begin
      cyc();
      check_val("bp_hold_pc", 64'(fd_pc_o), 64'h200);
      check_val("bp_hold_valid", 64'(fd_valid_o), 64'h1);
      if (i >= 2) check_val("bp_no_req", 64'(imem_req_valid_o), 64'h0);
    end
    check_val("bp_req_count", 64'(req_q.size()), 64'h2);
    check_val("bp_req1", 64'(req_q[1]), 64'h208);
    fd_ready_i = 1'b1;
    wait_bundles(2);
    check_val("bp_b0_pc", 64'(bpc_q[0]), 64'h200);
    check_val("bp_b1_pc", 64'(bpc_q[1]), 64'h208);
    check_val("bp_b1_instr", binstr_q[1], 64'h1000_020C_1000_0208);
    wait_reqs(3);
    check_val("bp_req2", 64'(req_q[2]), 64'h210);

    // Top-of-address-space wrap and low-bit masking of the redirect target
    redirect_to(32'hFFFF_FFFF);
    wait_reqs(2);
    check_val("wrap_req0", 64'(req_q[0]), 64'hFFFF_FFF8);
    check_val("wrap_req1", 64'(req_q[1]), 64'h0);
    wait_bundles(1);
    check_val("wrap_b0_pc", 64'(bpc_q[0]), 64'hFFFF_FFFC);
    check_val("wrap_b0_mask", 64'(bmask_q[0]), 64'h2);
    check_val("wrap_b0_instr", binstr_q[0], 64'h0FFF_FFFC_0000_0000);

    // Halt raised in WAIT, redirect while halted, then resume
    lat = 2;
    redirect_to(32'h0000_0400);
    wait_req_valid();
    cyc();
    halt_i = 1'b1;
    wait_bundles(1);
    check_val("halt_b0_pc", 64'(bpc_q[0]), 64'h400);
    check_val("halt_b0_mask", 64'(bmask_q[0]), 64'h3);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_val("halt_no_req", 64'(imem_req_valid_o), 64'h0);
    end
    check_val("halt_req_count", 64'(req_q.size()), 64'h1);
    check_val("halt_req0", 64'(req_q[0]), 64'h400);
    redirect_to(32'h0000_0300);
    check_val("halt_rd_addr", 64'(imem_req_addr_o), 64'h300);
    check_val("halt_rd_no_req", 64'(imem_req_valid_o), 64'h0);
    halt_i = 1'b0;
    #1;
    check_val("halt_resume_valid", 64'(imem_req_valid_o), 64'h1);
    wait_reqs(1);
    check_val("halt_resume_addr", 64'(req_q[0]), 64'h300);

    // Asynchronous reset in WAIT; the late response must be ignored
    redirect_to(32'h0000_0500);
    wait_req_valid();
    cyc();
    check_val("ar_pre_addr", 64'(imem_req_addr_o), 64'h500);
    rst_n = 1'b0;
    #1;
    check_val("ar_req_valid", 64'(imem_req_valid_o), 64'h0);
    check_val("ar_req_addr", 64'(imem_req_addr_o), 64'h0);
    check_val("ar_fd_valid", 64'(fd_valid_o), 64'h0);
    check_val("ar_fd_instr", fd_instr_o, 64'h0);
    cyc();
    clear_q();
    rst_n = 1'b1;
    wait_bundles(1);
    check_val("ar_b0_pc", 64'(bpc_q[0]), 64'h0);
    check_val("ar_b0_instr", binstr_q[0], 64'h1000_0004_1000_0000);
    check_val("ar_req0", 64'(req_q[0]), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
